// File: rtl/bsg_sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out buffer and its PISO peer.
package bsg_sipo_pkg;

  typedef enum logic {
    SIPO_OVERLAP = 1'b0,
    SIPO_MIN_BUF = 1'b1
  } sipo_mode_e;

  function automatic int sipo_ctr_width(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  localparam int SIPO_DEFAULT_ELS   = 4;
  localparam int SIPO_DEFAULT_CTR_W = sipo_ctr_width(SIPO_DEFAULT_ELS);

endpackage

// File: rtl/bsg_sipo_index_ctr.sv
// Wrapping word counter with element-index mapping, shared by the SIPO and PISO sides.
// Optional range assertion under BSG_SIPO_PROTOCOL_CHECK_EN.
module bsg_sipo_index_ctr
  import bsg_sipo_pkg::*;
#(
  parameter int els_p      = 4,
  parameter int hi_to_lo_p = 0,
  localparam int ctr_w_lp  = sipo_ctr_width(els_p)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                inc_i,
  output logic                last_o,
  output logic [ctr_w_lp-1:0] idx_o
);

  localparam logic [ctr_w_lp-1:0] last_cnt_lp = ctr_w_lp'(els_p - 1);

  logic [ctr_w_lp-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) begin
      cnt_d = (cnt_q == last_cnt_lp) ? '0 : cnt_q + ctr_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == last_cnt_lp);

  generate
    if (hi_to_lo_p != 0) begin : g_hi_to_lo
      assign idx_o = last_cnt_lp - cnt_q;
    end else begin : g_lo_to_hi
      assign idx_o = cnt_q;
    end
  endgenerate

`ifdef BSG_SIPO_PROTOCOL_CHECK_EN
  a_cnt_range : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    int'(cnt_q) < els_p)
    else $error("%m: word counter out of range (%0d)", cnt_q);
`else
`endif

endmodule

// File: rtl/bsg_serial_in_parallel_out_buffered.sv
// Rebuilds els_p-word vectors from a ready/valid word stream; valid/yumi output.
// Protocol assertions and a vector count are added when BSG_SIPO_PROTOCOL_CHECK_EN is defined.
module bsg_serial_in_parallel_out_buffered
  import bsg_sipo_pkg::*;
#(
  parameter int width_p                 = 16,
  parameter int els_p                   = 4,
  parameter int hi_to_lo_p              = 0,
  parameter int use_minimal_buffering_p = 0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     valid_i,
  input  logic [width_p-1:0]       data_i,
  output logic                     ready_and_o,
  output logic                     valid_o,
  output logic [els_p*width_p-1:0] data_o,
  input  logic                     yumi_i
);

  localparam int ctr_w_lp = sipo_ctr_width(els_p);
  localparam sipo_mode_e mode_lp =
    (use_minimal_buffering_p != 0) ? SIPO_MIN_BUF : SIPO_OVERLAP;
  // Element that receives the final word of a vector; it needs no assembly slot.
  localparam int last_elem_lp = (hi_to_lo_p != 0) ? 0 : els_p - 1;

  logic                en_q;
  logic                accept;
  logic                accept_last;
  logic                last;
  logic [ctr_w_lp-1:0] idx;

  // Holds ready low for the first cycle after reset release.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  assign accept      = valid_i & ready_and_o;
  assign accept_last = accept & last;

  bsg_sipo_index_ctr #(
    .els_p     (els_p),
    .hi_to_lo_p(hi_to_lo_p)
  ) u_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .inc_i    (accept),
    .last_o   (last),
    .idx_o    (idx)
  );

  generate
    if (mode_lp == SIPO_MIN_BUF) begin : g_min
      logic v_q, v_d;

      assign ready_and_o = en_q & ~v_q;
      assign valid_o     = v_q;

      always_comb begin
        v_d = v_q;
        if (accept_last) begin
          v_d = 1'b1;
        end else if (yumi_i) begin
          v_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          v_q <= 1'b0;
        end else begin
          v_q <= v_d;
        end
      end

      for (genvar gi = 0; gi < els_p; gi++) begin : g_elem
        logic [width_p-1:0] elem_q;

        always_ff @(posedge clk_i or negedge reset_n_i) begin
          if (!reset_n_i) begin
            elem_q <= '0;
          end else if (accept && (idx == ctr_w_lp'(gi))) begin
            elem_q <= data_i;
          end
        end

        assign data_o[gi*width_p +: width_p] = elem_q;
      end
    end else begin : g_ovl
      logic out_v_q, out_v_d;

      // Stall only when the final word would overwrite a vector still held.
      assign ready_and_o = en_q & ~(last & out_v_q);
      assign valid_o     = out_v_q;

      always_comb begin
        out_v_d = out_v_q;
        if (accept_last) begin
          out_v_d = 1'b1;
        end else if (yumi_i) begin
          out_v_d = 1'b0;
        end
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          out_v_q <= 1'b0;
        end else begin
          out_v_q <= out_v_d;
        end
      end

      for (genvar gi = 0; gi < els_p; gi++) begin : g_elem
        logic [width_p-1:0] out_q;

        if (gi == last_elem_lp) begin : g_tail
          always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
              out_q <= '0;
            end else if (accept_last) begin
              out_q <= data_i;
            end
          end
        end else begin : g_body
          logic [width_p-1:0] asm_q;

          always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
              asm_q <= '0;
            end else if (accept && (idx == ctr_w_lp'(gi))) begin
              asm_q <= data_i;
            end
          end

          always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
              out_q <= '0;
            end else if (accept_last) begin
              out_q <= asm_q;
            end
          end
        end

        assign data_o[gi*width_p +: width_p] = out_q;
      end
    end
  endgenerate

`ifdef BSG_SIPO_PROTOCOL_CHECK_EN
  int unsigned vec_count_q;

  always @(posedge clk_i) begin
    if (reset_n_i && accept_last) begin
      vec_count_q <= vec_count_q + 1;
    end
  end

  final $display("%m: %0d vectors completed", vec_count_q);

  a_yumi_legal : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(yumi_i && !valid_o))
    else $error("%m: yumi_i asserted while valid_o is low");

  a_data_hold : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (valid_i && !ready_and_o) |=> (!valid_i || $stable(data_i)))
    else $error("%m: data_i changed while stalled");
`else
`endif

endmodule

// File: tb/tb_bsg_serial_in_parallel_out_buffered.sv
// Bench for the SIPO buffer: six configurations driven side by side against a word-list model.
module tb_bsg_serial_in_parallel_out_buffered;

  localparam int N = 6;
  // Instance configs: bit i selects els_p=1, hi_to_lo_p=1, minimal buffering.
  localparam bit [N-1:0] ONE_V = 6'b110000;
  localparam bit [N-1:0] HI_V  = 6'b000010;
  localparam bit [N-1:0] MIN_V = 6'b101100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin  [N];
  logic [15:0] din  [N];
  logic        yumi [N];
  logic        rdy  [N];
  logic        vo   [N];
  logic [63:0] dout [N];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    if (!ONE_V[gi]) begin : g4
      bsg_serial_in_parallel_out_buffered #(
        .width_p(16), .els_p(4),
        .hi_to_lo_p(int'(HI_V[gi])),
        .use_minimal_buffering_p(int'(MIN_V[gi]))
      ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(vin[gi]), .data_i(din[gi]),
        .ready_and_o(rdy[gi]), .valid_o(vo[gi]), .data_o(dout[gi]), .yumi_i(yumi[gi])
      );
    end else begin : g1
      logic [15:0] d1;
      bsg_serial_in_parallel_out_buffered #(
        .width_p(16), .els_p(1), .hi_to_lo_p(0),
        .use_minimal_buffering_p(int'(MIN_V[gi]))
      ) u_dut (
        .clk_i(clk), .reset_n_i(rst_n), .valid_i(vin[gi]), .data_i(din[gi]),
        .ready_and_o(rdy[gi]), .valid_o(vo[gi]), .data_o(d1), .yumi_i(yumi[gi])
      );
      assign dout[gi] = {48'h0, d1};
    end
  end

  // Reference model: list of words collected so far plus the presented vector.
  bit          m_init;
  bit          m_ov [N];
  logic [63:0] m_od [N];
  logic [15:0] m_w  [N][4];
  int          m_n  [N];
  int          checks = 0;
  int          errors = 0;

  function automatic int els(input int i);
    return ONE_V[i] ? 1 : 4;
  endfunction

  function automatic bit m_ready(input int i);
    if (!m_init) return 1'b0;
    if (MIN_V[i]) return !m_ov[i];
    return !((m_n[i] == els(i) - 1) && m_ov[i]);
  endfunction

  task automatic model_reset();
    m_init = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_ov[i] = 1'b0;
      m_od[i] = '0;
      m_n[i]  = 0;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < N; i++) begin
      vin[i]  = 1'b0;
      yumi[i] = 1'b0;
      din[i]  = '0;
    end
  endtask

  // One clock: predict handshakes from pre-edge inputs, advance model, compare.
  task automatic cycle();
    bit          acc [N];
    bit          pop [N];
    logic [63:0] v;
    for (int i = 0; i < N; i++) begin
      acc[i] = vin[i] && m_ready(i);
      pop[i] = yumi[i] && m_ov[i];
    end
    @(posedge clk);
    m_init = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        m_w[i][m_n[i]] = din[i];
        m_n[i]++;
      end
      if (acc[i] && m_n[i] == els(i)) begin
        v = '0;
        for (int k = 0; k < els(i); k++)
          v[k*16 +: 16] = HI_V[i] ? m_w[i][els(i)-1-k] : m_w[i][k];
        m_od[i] = v;
        m_ov[i] = 1'b1;
        m_n[i]  = 0;
        $display("vec inst%0d data=%h", i, v);
      end else if (pop[i]) begin
        m_ov[i] = 1'b0;
      end
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("ready%0d", i), 64'(rdy[i]), 64'(m_ready(i)));
      chk($sformatf("valid%0d", i), 64'(vo[i]), 64'(m_ov[i]));
      if (m_ov[i]) chk($sformatf("data%0d", i), dout[i], m_od[i]);
    end
  endtask

  // Push n words into instance i (others idle), bounded by a cycle budget.
  task automatic send(input int i, input logic [15:0] base, input int n, input bit auto_yumi);
    int k = 0;
    int c = 0;
    while (k < n && c < 4 * n + 10) begin
      vin[i]  = 1'b1;
      din[i]  = 16'(base + 16'(k));
      yumi[i] = auto_yumi && m_ov[i];
      if (m_ready(i)) k++;
      cycle();
      c++;
    end
    vin[i]  = 1'b0;
    yumi[i] = 1'b0;
    chk($sformatf("send%0d_done", i), 64'(k), 64'(n));
  endtask

  task automatic drain();
    for (int i = 0; i < N; i++) begin
      vin[i]  = 1'b0;
      yumi[i] = m_ov[i];
    end
    cycle();
    idle();
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        y;
    logic        e_rdy;
    logic        e_vo;
    logic [63:0] e_lo;
    logic [63:0] e_hi;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] held;

    tbl[0] = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
    tbl[1] = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
    tbl[2] = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 64'h0, 64'h0};
    tbl[3] = '{1'b1, 16'h4444, 1'b0, 1'b1, 1'b1,
               64'h4444_3333_2222_1111, 64'h1111_2222_3333_4444};
    tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0};

    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_valid%0d", i), 64'(vo[i]), 64'h0);
      chk($sformatf("rst_ready%0d", i), 64'(rdy[i]), 64'h0);
      chk($sformatf("rst_data%0d", i), dout[i], 64'h0);
    end
    rst_n = 1'b1;
    cycle();

    // Table: assembly order for lo-to-hi and hi-to-lo overlap instances.
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < N; i++) begin
        vin[i]  = tbl[r].v;
        din[i]  = tbl[r].d;
        yumi[i] = tbl[r].y && m_ov[i];
      end
      cycle();
      for (int j = 0; j < 2; j++) begin
        chk($sformatf("tbl%0d_rdy%0d", r, j), 64'(rdy[j]), 64'(tbl[r].e_rdy));
        chk($sformatf("tbl%0d_vo%0d", r, j), 64'(vo[j]), 64'(tbl[r].e_vo));
        if (tbl[r].e_vo)
          chk($sformatf("tbl%0d_data%0d", r, j), dout[j], (j == 0) ? tbl[r].e_lo : tbl[r].e_hi);
      end
    end
    idle();

    // Minimal buffering: held vector blocks input until the cycle after yumi.
    send(2, 16'hC000, 4, 1'b0);
    chk("minbuf_valid", 64'(vo[2]), 64'h1);
    chk("minbuf_data", dout[2], 64'hC003_C002_C001_C000);
    held = dout[2];
    for (int c = 0; c < 5; c++) begin
      vin[2] = 1'b1;
      din[2] = 16'hDEAD;
      cycle();
      chk("minbuf_hold_rdy", 64'(rdy[2]), 64'h0);
      chk("minbuf_hold_data", dout[2], held);
    end
    yumi[2] = 1'b1;
    cycle();
    chk("minbuf_rdy_after_yumi", 64'(rdy[2]), 64'h1);
    yumi[2] = 1'b0;
    cycle();
    idle();

    // Overlap throughput: 16 back-to-back words with a prompt consumer.
    for (int j = 0; j < 16; j++) begin
      chk("tput_rdy", 64'(rdy[0]), 64'h1);
      vin[0]  = 1'b1;
      din[0]  = 16'(16'hA001 + 16'(j));
      yumi[0] = m_ov[0];
      cycle();
    end
    idle();
    chk("tput_last_valid", 64'(vo[0]), 64'h1);
    chk("tput_last_data", dout[0], 64'hA010_A00F_A00E_A00D);
    yumi[0] = 1'b1;
    cycle();
    idle();

    // Overlap stall: three more words fit behind a held vector, the fourth waits.
    send(0, 16'hB000, 4, 1'b0);
    send(0, 16'hB100, 3, 1'b0);
    chk("stall_rdy", 64'(rdy[0]), 64'h0);
    vin[0] = 1'b1;
    din[0] = 16'hB103;
    cycle();
    chk("stall_rdy_hold", 64'(rdy[0]), 64'h0);
    chk("stall_held_data", dout[0], 64'hB003_B002_B001_B000);
    yumi[0] = 1'b1;
    cycle();
    chk("stall_rdy_release", 64'(rdy[0]), 64'h1);
    yumi[0] = 1'b0;
    cycle();
    chk("stall_new_valid", 64'(vo[0]), 64'h1);
    chk("stall_new_data", dout[0], 64'hB103_B102_B101_B100);
    idle();

    // Asynchronous reset in the middle of a vector.
    drain();
    send(0, 16'hE000, 2, 1'b1);
    send(1, 16'hE000, 2, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("midrst_valid%0d", i), 64'(vo[i]), 64'h0);
      chk($sformatf("midrst_ready%0d", i), 64'(rdy[i]), 64'h0);
      chk($sformatf("midrst_data%0d", i), dout[i], 64'h0);
    end
    #2;
    rst_n = 1'b1;
    cycle();
    send(0, 16'hF000, 4, 1'b0);
    chk("postrst_data0", dout[0], 64'hF003_F002_F001_F000);
    send(1, 16'hF000, 4, 1'b0);
    chk("postrst_data1", dout[1], 64'hF000_F001_F002_F003);
    drain();

    // Single-element instances behave as a register slice.
    for (int i = 4; i < N; i++) begin
      vin[i] = 1'b1;
      din[i] = 16'hBEEF;
      cycle();
      chk($sformatf("els1_valid%0d", i), 64'(vo[i]), 64'h1);
      chk($sformatf("els1_data%0d", i), dout[i], 64'h0000_0000_0000_BEEF);
      chk($sformatf("els1_rdy_full%0d", i), 64'(rdy[i]), 64'h0);
      din[i]  = 16'hCAFE;
      yumi[i] = 1'b1;
      cycle();
      chk($sformatf("els1_rdy_free%0d", i), 64'(rdy[i]), 64'h1);
      yumi[i] = 1'b0;
      cycle();
      chk($sformatf("els1_data2_%0d", i), dout[i], 64'h0000_0000_0000_CAFE);
      idle();
    end
    drain();

    // Randomized traffic on every instance against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        vin[i]  = ($urandom_range(0, 3) != 0);
        din[i]  = 16'($urandom);
        yumi[i] = m_ov[i] && ($urandom_range(0, 2) != 0);
      end
      cycle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
